exu_seq_ctrl: RTL and testbench
===============================

Name: exu_seq_ctrl

Overview:
- Sequencing controller in front of the execute unit (ALU + branch/next-PC logic).
- Accepts one decoded instruction bundle from IDU over valid/ready and registers operands and control.
- Holds the bundle stable on the EXU inputs for 1 cycle (single-cycle class) or MC_LAT cycles (multi-cycle class), then presents result and next PC to WBU over valid/ready.
- Pulses the PC write-enable at retire; supports flush.

Parameters:
WIDTH, 32, datapath width of pc/imm/operands/result.
MC_LAT, 4, EXU occupancy in cycles for multi-cycle ops; legal range 2..15.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  IDU bundle valid
in_ready  out  1  controller can accept bundle
in_pc / in_imm / in_rs1 / in_rs2  in  WIDTH each  bundle operands
in_alu_ctrl  in  9  ALU operation select
in_s1_sel / in_s2_sel  in  1 each  ALU source selects (s1: 1=rs1, 0=pc; s2: 1=imm, 0=rs2)
in_branch_sel  in  4  branch type, 0 = not a branch
in_mc  in  1  multi-cycle class
exu_pc / exu_imm / exu_rs1 / exu_rs2  out  WIDTH each  registered operands to EXU
exu_alu_ctrl  out  9  registered
exu_s1_sel / exu_s2_sel  out  1 each  registered
exu_branch_sel  out  4  registered
exu_alu_result / exu_next_pc / exu_pc_add4  in  WIDTH each  EXU outputs
out_valid  out  1  result valid to WBU
out_ready  in  1  WBU accepts
out_result  out  WIDTH  captured alu result
out_next_pc  out  WIDTH  captured next pc
pc_we  out  1  one-cycle PC update strobe
redirect  out  1  qualifies pc_we; next_pc != pc_add4
flush  in  1  drop in-flight instruction

Behaviour:
- Reset (async, rst=1): state IDLE. All exu_* registers, out_result and out_next_pc = 0. out_valid=0, pc_we=0, redirect=0, counter=0.
- FSM states: IDLE, EXEC, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, capture the bundle into exu_* regs.
  - Next state: BUSY with cnt=MC_LAT-2 if in_mc, else EXEC.
- EXEC (one cycle):
  - Sample exu_alu_result, exu_next_pc and exu_pc_add4 into out_result / out_next_pc / redirect flag.
  - Next state: DONE.
- BUSY:
  - exu_* regs held constant.
  - cnt decrements each cycle.
  - When cnt==0, sample results as in EXEC, then go to DONE.
  - Total cycles from capture to DONE = MC_LAT.
- DONE:
  - out_valid=1; outputs stable until handshake.
  - On out_valid&out_ready: pc_we=1 for exactly this cycle, redirect = (captured next_pc != captured pc_add4).
  - in_ready = out_ready in DONE, so a new bundle may be captured in the same cycle (back-to-back). Next state is then EXEC/BUSY; otherwise IDLE.
- pc_we and redirect are combinational from the DONE handshake; redirect=0 whenever pc_we=0.
- Latency:
  - Single-cycle op: capture edge → out_valid two edges later.
  - Multi-cycle op: MC_LAT+1 edges.
- Throughput with out_ready held high: 1 instruction per 2 cycles (single), per MC_LAT+1 cycles (multi).
- flush:
  - Highest priority; in any state the next state is IDLE and out_valid falls next cycle.
  - pc_we is forced to 0 in the flush cycle.
  - in_ready=0 while flush=1, so nothing is captured.
  - exu_* regs keep their values.
- in_valid with in_ready=0: bundle ignored; IDU must hold it.
- Simultaneous DONE handshake and flush: flush wins; no pc_we.
- rst asserted mid-BUSY: immediate return to reset values; counter cleared.

Optional Feature:
- Macro: EXU_SEQ_PERF_CNT_EN.
- Defined:
  - Adds 32-bit outputs perf_retired (increments on each pc_we) and perf_stall.
  - perf_stall increments each cycle in DONE with out_ready=0, or in BUSY.
  - Both cleared by rst, saturate at 0xFFFFFFFF.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package: state encoding (IDLE=0, EXEC=1, BUSY=2, DONE=3), ALU_CTRL_W=9, BRANCH_SEL_W=4, BR_NONE=0.
- One natural sub-module: exu_seq_lat_cnt, a down-counter with load/dec/zero flag, width $clog2(MC_LAT).

Test Plan:
- Single ALU op (in_mc=0, rs1=5, imm=7, add), out_ready=1 → out_valid 2 cycles after capture, out_result=12, pc_we=1 for one cycle, redirect=0.
- Multi-cycle op with MC_LAT=4 → exu_* regs constant for 4 cycles, out_valid asserts on the 5th edge after capture, in_ready=0 throughout.
- Taken branch, pc=0x80000000, imm=0x10 → out_next_pc=0x80000010, redirect=1 together with pc_we.
- Back-pressure: out_ready=0 for 3 cycles in DONE → out_result and out_next_pc stable, no pc_we; then out_ready=1 with in_valid=1 → new bundle captured in the same cycle.
- Flush in BUSY (cnt=1) → next cycle IDLE, out_valid never asserts, pc_we stays 0.
- Async rst pulse mid-BUSY, between clock edges → outputs zero immediately, state IDLE, next in_valid accepted normally.

Source files
------------

// File: rtl/exu_seq_ctrl_pkg.sv
// Shared types and constants for the EXU sequencing controller.
package exu_seq_ctrl_pkg;

  localparam int ALU_CTRL_W   = 9;
  localparam int BRANCH_SEL_W = 4;

  localparam logic [BRANCH_SEL_W-1:0] BR_NONE = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_BUSY = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/exu_seq_ctrl_if.sv
// IDU-side bundle, EXU operand/result signals and WBU-side result/PC-update signals.
interface exu_seq_ctrl_if #(
  parameter int WIDTH = 32
);
  import exu_seq_ctrl_pkg::*;

  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        in_pc;
  logic [WIDTH-1:0]        in_imm;
  logic [WIDTH-1:0]        in_rs1;
  logic [WIDTH-1:0]        in_rs2;
  logic [ALU_CTRL_W-1:0]   in_alu_ctrl;
  logic                    in_s1_sel;
  logic                    in_s2_sel;
  logic [BRANCH_SEL_W-1:0] in_branch_sel;
  logic                    in_mc;

  logic [WIDTH-1:0]        exu_pc;
  logic [WIDTH-1:0]        exu_imm;
  logic [WIDTH-1:0]        exu_rs1;
  logic [WIDTH-1:0]        exu_rs2;
  logic [ALU_CTRL_W-1:0]   exu_alu_ctrl;
  logic                    exu_s1_sel;
  logic                    exu_s2_sel;
  logic [BRANCH_SEL_W-1:0] exu_branch_sel;
  logic [WIDTH-1:0]        exu_alu_result;
  logic [WIDTH-1:0]        exu_next_pc;
  logic [WIDTH-1:0]        exu_pc_add4;

  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        out_result;
  logic [WIDTH-1:0]        out_next_pc;
  logic                    pc_we;
  logic                    redirect;
  logic                    flush;

  modport slave (
    input  in_valid, in_pc, in_imm, in_rs1, in_rs2, in_alu_ctrl,
           in_s1_sel, in_s2_sel, in_branch_sel, in_mc,
           exu_alu_result, exu_next_pc, exu_pc_add4,
           out_ready, flush,
    output in_ready,
           exu_pc, exu_imm, exu_rs1, exu_rs2, exu_alu_ctrl,
           exu_s1_sel, exu_s2_sel, exu_branch_sel,
           out_valid, out_result, out_next_pc, pc_we, redirect
  );

  modport master (
    output in_valid, in_pc, in_imm, in_rs1, in_rs2, in_alu_ctrl,
           in_s1_sel, in_s2_sel, in_branch_sel, in_mc,
           exu_alu_result, exu_next_pc, exu_pc_add4,
           out_ready, flush,
    input  in_ready,
           exu_pc, exu_imm, exu_rs1, exu_rs2, exu_alu_ctrl,
           exu_s1_sel, exu_s2_sel, exu_branch_sel,
           out_valid, out_result, out_next_pc, pc_we, redirect
  );

endinterface

// File: rtl/exu_seq_lat_cnt.sv
// Multi-cycle occupancy down-counter: loads MC_LAT-2, decrements to zero and holds there.
module exu_seq_lat_cnt #(
  parameter int MC_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int CNT_W = $clog2(MC_LAT);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(MC_LAT - 2);
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/exu_seq_ctrl.sv
// EXU sequencing controller: registers an IDU bundle, holds it for the EXU latency, hands the result to WBU.
// Optional perf counters (perf_retired, perf_stall) are built when EXU_SEQ_PERF_CNT_EN is defined.
module exu_seq_ctrl
  import exu_seq_ctrl_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int MC_LAT = 4
) (
  input  logic               clk,
  input  logic               rst,
  exu_seq_ctrl_if.slave      bus
`ifdef EXU_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]        perf_retired,
  output logic [31:0]        perf_stall
`endif
);

  state_t state_q, state_d;

  logic capture, sample, cnt_load, cnt_dec, cnt_zero;
  logic in_ready, pc_we, redirect_q;

  logic [WIDTH-1:0]        pc_q, imm_q, rs1_q, rs2_q, result_q, next_pc_q;
  logic [ALU_CTRL_W-1:0]   alu_ctrl_q;
  logic                    s1_sel_q, s2_sel_q;
  logic [BRANCH_SEL_W-1:0] branch_sel_q;

  exu_seq_lat_cnt #(.MC_LAT(MC_LAT)) u_lat_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .dec  (cnt_dec),
    .zero (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // BUSY hands over to EXEC once the counter drains, so EXEC is the single sampling point.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    sample   = 1'b0;
    cnt_dec  = 1'b0;
    pc_we    = 1'b0;
    capture  = 1'b0;
    cnt_load = 1'b0;
    case (state_q)
      ST_IDLE: in_ready = 1'b1;
      ST_EXEC: begin
        sample  = 1'b1;
        state_d = ST_DONE;
      end
      ST_BUSY: begin
        if (cnt_zero) state_d = ST_EXEC;
        else          cnt_dec = 1'b1;
      end
      ST_DONE: begin
        in_ready = bus.out_ready;
        if (bus.out_ready) begin
          pc_we   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (bus.flush) begin
      in_ready = 1'b0;
      pc_we    = 1'b0;
      sample   = 1'b0;
      state_d  = ST_IDLE;
    end
    capture = bus.in_valid && in_ready;
    if (capture) begin
      state_d  = bus.in_mc ? ST_BUSY : ST_EXEC;
      cnt_load = bus.in_mc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q         <= '0;
      imm_q        <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      alu_ctrl_q   <= '0;
      s1_sel_q     <= 1'b0;
      s2_sel_q     <= 1'b0;
      branch_sel_q <= '0;
    end else if (capture) begin
      pc_q         <= bus.in_pc;
      imm_q        <= bus.in_imm;
      rs1_q        <= bus.in_rs1;
      rs2_q        <= bus.in_rs2;
      alu_ctrl_q   <= bus.in_alu_ctrl;
      s1_sel_q     <= bus.in_s1_sel;
      s2_sel_q     <= bus.in_s2_sel;
      branch_sel_q <= bus.in_branch_sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q   <= '0;
      next_pc_q  <= '0;
      redirect_q <= 1'b0;
    end else if (sample) begin
      result_q   <= bus.exu_alu_result;
      next_pc_q  <= bus.exu_next_pc;
      redirect_q <= (bus.exu_next_pc != bus.exu_pc_add4);
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.exu_pc         = pc_q;
  assign bus.exu_imm        = imm_q;
  assign bus.exu_rs1        = rs1_q;
  assign bus.exu_rs2        = rs2_q;
  assign bus.exu_alu_ctrl   = alu_ctrl_q;
  assign bus.exu_s1_sel     = s1_sel_q;
  assign bus.exu_s2_sel     = s2_sel_q;
  assign bus.exu_branch_sel = branch_sel_q;
  assign bus.out_valid      = (state_q == ST_DONE);
  assign bus.out_result     = result_q;
  assign bus.out_next_pc    = next_pc_q;
  assign bus.pc_we          = pc_we;
  assign bus.redirect       = pc_we && redirect_q;

`ifdef EXU_SEQ_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_retired <= '0;
      perf_stall   <= '0;
    end else begin
      if (pc_we && (perf_retired != 32'hFFFF_FFFF))
        perf_retired <= perf_retired + 32'd1;
      if (((state_q == ST_DONE && !bus.out_ready) || state_q == ST_BUSY) &&
          (perf_stall != 32'hFFFF_FFFF))
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_exu_seq_ctrl.sv
// Directed plus randomized bench for exu_seq_ctrl against a transaction-level ALU/branch reference.
module tb_exu_seq_ctrl;
  import exu_seq_ctrl_pkg::*;

  localparam int WIDTH  = 32;
  localparam int MC_LAT = 4;

  localparam logic [ALU_CTRL_W-1:0]   OP_ADD = 9'd0;
  localparam logic [ALU_CTRL_W-1:0]   OP_SUB = 9'd1;
  localparam logic [ALU_CTRL_W-1:0]   OP_XOR = 9'd4;
  localparam logic [BRANCH_SEL_W-1:0] BR_JAL = 4'd1;
  localparam logic [BRANCH_SEL_W-1:0] BR_EQ  = 4'd2;
  localparam logic [BRANCH_SEL_W-1:0] BR_NE  = 4'd3;

  typedef struct {
    logic [31:0] pc, imm, rs1, rs2;
    logic [8:0]  alu_ctrl;
    logic        s1_sel, s2_sel;
    logic [3:0]  branch_sel;
    logic        mc;
  } bundle_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  exu_seq_ctrl_if #(.WIDTH(WIDTH)) bus();

`ifdef EXU_SEQ_PERF_CNT_EN
  logic [31:0] perf_retired, perf_stall;
  exu_seq_ctrl #(.WIDTH(WIDTH), .MC_LAT(MC_LAT)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .perf_retired(perf_retired), .perf_stall(perf_stall)
  );
`else
  exu_seq_ctrl #(.WIDTH(WIDTH), .MC_LAT(MC_LAT)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
`endif

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_model(input logic [8:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      9'd0:    return a + b;
      9'd1:    return a - b;
      9'd2:    return a & b;
      9'd3:    return a | b;
      9'd4:    return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] npc_model(input logic [3:0] br, input logic [31:0] pc,
                                            input logic [31:0] imm, input logic [31:0] a,
                                            input logic [31:0] b);
    if (br == BR_NONE)             return pc + 32'd4;
    if (br == BR_JAL)              return pc + imm;
    if (br == BR_EQ && a == b)     return pc + imm;
    if (br == BR_NE && a != b)     return pc + imm;
    return pc + 32'd4;
  endfunction

  // Behavioural EXU driven from the controller's registered operands.
  assign bus.exu_alu_result = alu_model(bus.exu_alu_ctrl,
                                        bus.exu_s1_sel ? bus.exu_rs1 : bus.exu_pc,
                                        bus.exu_s2_sel ? bus.exu_imm : bus.exu_rs2);
  assign bus.exu_next_pc    = npc_model(bus.exu_branch_sel, bus.exu_pc, bus.exu_imm,
                                        bus.exu_rs1, bus.exu_rs2);
  assign bus.exu_pc_add4    = bus.exu_pc + 32'd4;

  function automatic logic [31:0] exp_result(input bundle_t b);
    return alu_model(b.alu_ctrl, b.s1_sel ? b.rs1 : b.pc, b.s2_sel ? b.imm : b.rs2);
  endfunction

  function automatic logic [31:0] exp_npc(input bundle_t b);
    return npc_model(b.branch_sel, b.pc, b.imm, b.rs1, b.rs2);
  endfunction

  function automatic bundle_t mk(input logic [31:0] pc, input logic [31:0] imm,
                                 input logic [31:0] rs1, input logic [31:0] rs2,
                                 input logic [8:0] op, input logic s1, input logic s2,
                                 input logic [3:0] br, input logic mc);
    bundle_t b;
    b.pc = pc; b.imm = imm; b.rs1 = rs1; b.rs2 = rs2; b.alu_ctrl = op;
    b.s1_sel = s1; b.s2_sel = s2; b.branch_sel = br; b.mc = mc;
    return b;
  endfunction

  function automatic bundle_t rand_bundle();
    bundle_t b;
    b.pc         = $urandom & 32'hFFFF_FFFC;
    b.imm        = 32'($urandom_range(0, 255)) << 2;
    b.rs1        = $urandom;
    b.rs2        = ($urandom_range(0, 1) == 1) ? b.rs1 : $urandom;
    b.alu_ctrl   = 9'($urandom_range(0, 4));
    b.s1_sel     = 1'($urandom_range(0, 1));
    b.s2_sel     = 1'($urandom_range(0, 1));
    b.branch_sel = 4'($urandom_range(0, 3));
    b.mc         = 1'($urandom_range(0, 1));
    return b;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bundle_t b);
    bus.in_valid      = 1'b1;
    bus.in_pc         = b.pc;
    bus.in_imm        = b.imm;
    bus.in_rs1        = b.rs1;
    bus.in_rs2        = b.rs2;
    bus.in_alu_ctrl   = b.alu_ctrl;
    bus.in_s1_sel     = b.s1_sel;
    bus.in_s2_sel     = b.s2_sel;
    bus.in_branch_sel = b.branch_sel;
    bus.in_mc         = b.mc;
  endtask

  // Present a bundle while the controller is able to take it; returns just after the capture edge.
  task automatic issue(input bundle_t b);
    applyStimulus(b);
    #1 checkOutput("issue_in_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // Occupancy is 1 cycle for single-cycle ops, MC_LAT cycles for multi-cycle ops.
  task automatic expect_result(input bundle_t b);
    int lat;
    lat = b.mc ? MC_LAT : 1;
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      checkOutput("busy_out_valid", bus.out_valid, 1'b0);
      checkOutput("busy_in_ready", bus.in_ready, 1'b0);
      checkOutput("busy_pc_we", bus.pc_we, 1'b0);
      checkOutput("hold_exu_rs1", bus.exu_rs1, b.rs1);
      checkOutput("hold_exu_imm", bus.exu_imm, b.imm);
      checkOutput("hold_exu_alu_ctrl", 32'(bus.exu_alu_ctrl), 32'(b.alu_ctrl));
    end
    @(negedge clk);
    checkOutput("done_out_valid", bus.out_valid, 1'b1);
    checkOutput("done_out_result", bus.out_result, exp_result(b));
    checkOutput("done_out_next_pc", bus.out_next_pc, exp_npc(b));
  endtask

  task automatic stall(input bundle_t b, input int n);
    bus.out_ready = 1'b0;
    for (int k = 0; k < n; k++) begin
      #1 checkOutput("stall_pc_we", bus.pc_we, 1'b0);
      checkOutput("stall_redirect", bus.redirect, 1'b0);
      @(negedge clk);
      checkOutput("stall_out_valid", bus.out_valid, 1'b1);
      checkOutput("stall_out_result", bus.out_result, exp_result(b));
      checkOutput("stall_out_next_pc", bus.out_next_pc, exp_npc(b));
    end
    bus.out_ready = 1'b1;
  endtask

  task automatic handshake_check(input bundle_t b);
    #1 checkOutput("hs_pc_we", bus.pc_we, 1'b1);
    checkOutput("hs_redirect", bus.redirect, exp_npc(b) != b.pc + 32'd4);
  endtask

  task automatic retire();
    @(posedge clk);
    @(negedge clk);
    checkOutput("retire_out_valid", bus.out_valid, 1'b0);
    checkOutput("retire_pc_we", bus.pc_we, 1'b0);
    checkOutput("retire_in_ready", bus.in_ready, 1'b1);
  endtask

  initial begin
    bundle_t b, b2, cur, nxt;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.flush     = 1'b0;
    applyStimulus(mk(0, 0, 0, 0, OP_ADD, 0, 0, BR_NONE, 0));
    bus.in_valid  = 1'b0;

    #1;
    checkOutput("rst_out_valid", bus.out_valid, 1'b0);
    checkOutput("rst_pc_we", bus.pc_we, 1'b0);
    checkOutput("rst_redirect", bus.redirect, 1'b0);
    checkOutput("rst_exu_pc", bus.exu_pc, 32'd0);
    checkOutput("rst_exu_alu_ctrl", 32'(bus.exu_alu_ctrl), 32'd0);
    checkOutput("rst_out_result", bus.out_result, 32'd0);
    checkOutput("rst_out_next_pc", bus.out_next_pc, 32'd0);
    checkOutput("rst_in_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] single-cycle add");
    b = mk(32'h100, 32'd7, 32'd5, 32'd0, OP_ADD, 1, 1, BR_NONE, 0);
    issue(b);
    expect_result(b);
    checkOutput("add_result_12", bus.out_result, 32'd12);
    handshake_check(b);
    retire();

    $display("[TB] multi-cycle sub");
    b = mk(32'h200, 32'd3, 32'd100, 32'd40, OP_SUB, 1, 0, BR_NONE, 1);
    issue(b);
    expect_result(b);
    handshake_check(b);
    retire();

    $display("[TB] taken branch");
    b = mk(32'h8000_0000, 32'h10, 32'd1, 32'd2, OP_ADD, 0, 1, BR_JAL, 0);
    issue(b);
    expect_result(b);
    checkOutput("branch_next_pc", bus.out_next_pc, 32'h8000_0010);
    #1 checkOutput("branch_redirect", bus.redirect, 1'b1);
    checkOutput("branch_pc_we", bus.pc_we, 1'b1);
    retire();

    $display("[TB] back-pressure then back-to-back capture");
    b  = mk(32'h300, 32'h0F0F, 32'hFF00, 32'd0, OP_XOR, 1, 1, BR_NONE, 0);
    b2 = mk(32'h304, 32'd8, 32'd9, 32'd9, OP_ADD, 1, 0, BR_EQ, 0);
    issue(b);
    expect_result(b);
    stall(b, 3);
    handshake_check(b);
    issue(b2);
    expect_result(b2);
    handshake_check(b2);
    retire();

    $display("[TB] flush while busy");
    b  = mk(32'h400, 32'd1, 32'h1234, 32'd2, OP_ADD, 1, 1, BR_NONE, 1);
    b2 = mk(32'h500, 32'd2, 32'h9999, 32'd3, OP_ADD, 1, 1, BR_NONE, 0);
    issue(b);
    @(negedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    applyStimulus(b2);
    #1 checkOutput("flush_in_ready", bus.in_ready, 1'b0);
    checkOutput("flush_pc_we", bus.pc_we, 1'b0);
    @(posedge clk);
    #1 bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    for (int k = 0; k < MC_LAT + 1; k++) begin
      @(negedge clk);
      checkOutput("flush_out_valid", bus.out_valid, 1'b0);
      checkOutput("flush_pc_we_after", bus.pc_we, 1'b0);
      checkOutput("flush_exu_rs1_kept", bus.exu_rs1, b.rs1);
    end
    checkOutput("flush_idle_in_ready", bus.in_ready, 1'b1);

    $display("[TB] flush against a DONE handshake");
    b = mk(32'h600, 32'd11, 32'd22, 32'd0, OP_ADD, 1, 1, BR_NONE, 0);
    issue(b);
    expect_result(b);
    bus.flush = 1'b1;
    #1 checkOutput("flushhs_pc_we", bus.pc_we, 1'b0);
    checkOutput("flushhs_redirect", bus.redirect, 1'b0);
    checkOutput("flushhs_in_ready", bus.in_ready, 1'b0);
    @(posedge clk);
    #1 bus.flush = 1'b0;
    @(negedge clk);
    checkOutput("flushhs_out_valid", bus.out_valid, 1'b0);

    $display("[TB] async reset mid-busy");
    b = mk(32'h700, 32'd4, 32'hABCD, 32'd0, OP_ADD, 1, 1, BR_NONE, 1);
    issue(b);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 checkOutput("arst_exu_rs1", bus.exu_rs1, 32'd0);
    checkOutput("arst_out_result", bus.out_result, 32'd0);
    checkOutput("arst_out_next_pc", bus.out_next_pc, 32'd0);
    checkOutput("arst_out_valid", bus.out_valid, 1'b0);
    checkOutput("arst_in_ready", bus.in_ready, 1'b1);
    #1 rst = 1'b0;
    @(negedge clk);
    b = mk(32'h800, 32'd5, 32'd6, 32'd0, OP_ADD, 1, 1, BR_NONE, 1);
    issue(b);
    expect_result(b);
    handshake_check(b);
    retire();

    $display("[TB] randomized sequence");
    cur = rand_bundle();
    issue(cur);
    for (int i = 0; i < 24; i++) begin
      expect_result(cur);
      stall(cur, $urandom_range(0, 2));
      handshake_check(cur);
      if (i == 23) begin
        retire();
      end else begin
        nxt = rand_bundle();
        if ($urandom_range(0, 1) == 1) begin
          issue(nxt);
        end else begin
          retire();
          issue(nxt);
        end
        cur = nxt;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
